// File: rtl/unified_memory_arbiter.sv
// Two-port (fetch / data) arbiter in front of one fixed-latency single-ported RAM.
// Optional stall-cycle counters are enabled by defining ARB_PERF_COUNTERS_EN.
module unified_memory_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_LATENCY     = 2,
  parameter int DATA_STREAK_MAX = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ifReq,
  input  logic [DATA_WIDTH-1:0] ifAddr,
  output logic [DATA_WIDTH-1:0] ifData,
  output logic                  ifValid,
  output logic                  ifStall,
  input  logic                  memReq,
  input  logic                  memWe,
  input  logic [DATA_WIDTH-1:0] memAddr,
  input  logic [DATA_WIDTH-1:0] memWData,
  output logic [DATA_WIDTH-1:0] memRData,
  output logic                  memValid,
  output logic                  memStall,
`ifdef ARB_PERF_COUNTERS_EN
  output logic [31:0]           ifWaitCycles,
  output logic [31:0]           memWaitCycles,
`endif
  output logic                  ramEn,
  output logic                  ramWe,
  output logic [DATA_WIDTH-1:0] ramAddr,
  output logic [DATA_WIDTH-1:0] ramWData,
  input  logic [DATA_WIDTH-1:0] ramRData
);

  localparam int CNT_W    = $clog2(MEM_LATENCY + 1);
  localparam int STREAK_W = $clog2(DATA_STREAK_MAX + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX_C = STREAK_W'(DATA_STREAK_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

  state_t                r_state;
  owner_t                r_owner;
  logic [CNT_W-1:0]      r_cnt;
  logic [STREAK_W-1:0]   r_streak;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_ifData;
  logic [DATA_WIDTH-1:0] r_memRData;
  logic                  r_ifValid;
  logic                  r_memValid;
  logic                  r_ramEn;
  logic                  r_ramWe;
  logic [DATA_WIDTH-1:0] r_ramAddr;
  logic [DATA_WIDTH-1:0] r_ramWData;

  logic w_ifStall;
  logic w_memStall;

  assign w_ifStall  = ifReq  & ~r_ifValid;
  assign w_memStall = memReq & ~r_memValid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_owner    <= OWN_NONE;
      r_cnt      <= '0;
      r_streak   <= '0;
      r_we       <= 1'b0;
      r_ifData   <= '0;
      r_memRData <= '0;
      r_ifValid  <= 1'b0;
      r_memValid <= 1'b0;
      r_ramEn    <= 1'b0;
      r_ramWe    <= 1'b0;
      r_ramAddr  <= '0;
      r_ramWData <= '0;
    end else begin
      r_ifValid  <= 1'b0;
      r_memValid <= 1'b0;
      case (r_state)
        IDLE: begin
          // Data wins unless a waiting fetch has already been passed over too often.
          if (memReq && (!ifReq || (r_streak < STREAK_MAX_C))) begin
            r_owner    <= OWN_MEM;
            r_we       <= memWe;
            r_ramEn    <= 1'b1;
            r_ramWe    <= memWe;
            r_ramAddr  <= memAddr;
            r_ramWData <= memWData;
            if (!ifReq)
              r_streak <= '0;
            else if (r_streak < STREAK_MAX_C)
              r_streak <= r_streak + 1'b1;
            r_state <= ISSUE;
          end else if (ifReq) begin
            r_owner    <= OWN_IF;
            r_we       <= 1'b0;
            r_ramEn    <= 1'b1;
            r_ramWe    <= 1'b0;
            r_ramAddr  <= ifAddr;
            r_ramWData <= '0;
            r_streak   <= '0;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          r_ramEn <= 1'b0;
          r_ramWe <= 1'b0;
          r_cnt   <= CNT_W'(MEM_LATENCY);
          r_state <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            // Read data is only on the bus in this one cycle.
            if (r_owner == OWN_IF) begin
              r_ifData  <= ramRData;
              r_ifValid <= 1'b1;
            end else begin
              if (!r_we)
                r_memRData <= ramRData;
              r_memValid <= 1'b1;
            end
            r_state <= DONE;
          end
        end
        DONE: begin
          r_owner <= OWN_NONE;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_COUNTERS_EN
  logic [31:0] r_ifWaitCycles;
  logic [31:0] r_memWaitCycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ifWaitCycles  <= '0;
      r_memWaitCycles <= '0;
    end else begin
      if (w_ifStall)
        r_ifWaitCycles <= r_ifWaitCycles + 32'd1;
      if (w_memStall)
        r_memWaitCycles <= r_memWaitCycles + 32'd1;
    end
  end

  assign ifWaitCycles  = r_ifWaitCycles;
  assign memWaitCycles = r_memWaitCycles;
`endif

  assign ifData   = r_ifData;
  assign ifValid  = r_ifValid;
  assign ifStall  = w_ifStall;
  assign memRData = r_memRData;
  assign memValid = r_memValid;
  assign memStall = w_memStall;
  assign ramEn    = r_ramEn;
  assign ramWe    = r_ramWe;
  assign ramAddr  = r_ramAddr;
  assign ramWData = r_ramWData;

endmodule

// File: tb/tb_unified_memory_arbiter.sv
// Directed bench for unified_memory_arbiter: vector table of single-port accesses
// plus hand-written contention, starvation and reset sequences.
module tb_unified_memory_arbiter;

  localparam int DW = 32;
  localparam int L  = 2;
  localparam int SM = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          ifReq, memReq, memWe;
  logic [DW-1:0] ifAddr, memAddr, memWData;
  logic [DW-1:0] ifData, memRData, ramAddr, ramWData, ramRData;
  logic          ifValid, ifStall, memValid, memStall, ramEn, ramWe;
`ifdef ARB_PERF_COUNTERS_EN
  logic [31:0]   ifWaitCycles, memWaitCycles;
`endif

  always #5 clk = ~clk;

  unified_memory_arbiter #(.DATA_WIDTH(DW), .MEM_LATENCY(L), .DATA_STREAK_MAX(SM)) dut (
    .clk(clk), .reset(reset),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifData(ifData), .ifValid(ifValid), .ifStall(ifStall),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memValid(memValid), .memStall(memStall),
`ifdef ARB_PERF_COUNTERS_EN
    .ifWaitCycles(ifWaitCycles), .memWaitCycles(memWaitCycles),
`endif
    .ramEn(ramEn), .ramWe(ramWe), .ramAddr(ramAddr), .ramWData(ramWData), .ramRData(ramRData)
  );

  // Fixed-latency RAM: read data is on the bus only in the cycle L after ramEn.
  logic [DW-1:0] mem [0:255];
  logic          en_pipe   [0:L-1];
  logic [DW-1:0] addr_pipe [0:L-1];

  always @(posedge clk) begin
    en_pipe[0]   <= ramEn;
    addr_pipe[0] <= ramAddr;
    for (int i = 1; i < L; i++) begin
      en_pipe[i]   <= en_pipe[i-1];
      addr_pipe[i] <= addr_pipe[i-1];
    end
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= {24'hA5A5A5, i[7:0]};
      mem[8'h10] <= 32'h8C010004;
      mem[8'h20] <= 32'hCAFEF00D;
      mem[8'h40] <= 32'h12345678;
    end else if (ramEn && ramWe) begin
      mem[ramAddr[7:0]] <= ramWData;
    end
  end

  assign ramRData = en_pipe[L-1] ? mem[addr_pipe[L-1][7:0]] : 32'hBAD0BAD0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    logic          is_if;
    logic          we;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_data;
  } vec_t;

  task automatic run_txn(input vec_t v, input string tag);
    int   vcyc = -1;
    logic stall_bad = 1'b0;
    logic other_bad = 1'b0;
    @(posedge clk); #1;
    if (v.is_if) begin
      ifReq = 1'b1; ifAddr = v.addr;
    end else begin
      memReq = 1'b1; memWe = v.we; memAddr = v.addr; memWData = v.wdata;
    end
    for (int k = 0; k < 20 && vcyc < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({tag, " ramEn"}, {31'd0, ramEn}, 32'd1);
        check({tag, " ramAddr"}, ramAddr, v.addr);
        check({tag, " ramWe"}, {31'd0, ramWe}, {31'd0, v.we});
        if (v.we) check({tag, " ramWData"}, ramWData, v.wdata);
      end
      if (v.is_if ? ifValid : memValid) begin
        vcyc = k;
        check({tag, " stall at valid"}, {31'd0, v.is_if ? ifStall : memStall}, 32'd0);
        check({tag, " data"}, v.is_if ? ifData : memRData, v.exp_data);
      end else if ((v.is_if ? ifStall : memStall) !== 1'b1) begin
        stall_bad = 1'b1;
      end
      if (v.is_if ? memValid : ifValid) other_bad = 1'b1;
    end
    check({tag, " latency"}, vcyc, L + 2);
    check({tag, " stall held"}, {31'd0, stall_bad}, 32'd0);
    check({tag, " other port quiet"}, {31'd0, other_bad}, 32'd0);
    @(posedge clk); #1;
    ifReq = 1'b0; memReq = 1'b0; memWe = 1'b0;
  endtask

  vec_t vecs [6];

  initial begin
    int mv, iv, ie, ist, cnt;
    logic [DW-1:0] order [6];
    logic [DW-1:0] exp_order [6];
    logic bad;
`ifdef ARB_PERF_COUNTERS_EN
    logic [31:0] if_snap, mem_snap;
`endif

    vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0,        32'h8C010004};
    vecs[1] = '{1'b0, 1'b0, 32'h40, 32'h0,        32'h12345678};
    vecs[2] = '{1'b0, 1'b1, 32'h44, 32'hDEADBEEF, 32'h12345678}; // store keeps old memRData
    vecs[3] = '{1'b0, 1'b0, 32'h44, 32'h0,        32'hDEADBEEF};
    vecs[4] = '{1'b1, 1'b0, 32'h44, 32'h0,        32'hDEADBEEF};
    vecs[5] = '{1'b1, 1'b0, 32'h20, 32'h0,        32'hCAFEF00D};

    reset = 1'b1; ifReq = 1'b0; memReq = 1'b0; memWe = 1'b0;
    ifAddr = '0; memAddr = '0; memWData = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset ramEn/ramWe/valids/stalls",
          {26'd0, ramEn, ramWe, ifValid, memValid, ifStall, memStall}, 32'd0);
    check("reset ifData", ifData, 32'd0);
    check("reset memRData", memRData, 32'd0);
    check("reset ramAddr", ramAddr, 32'd0);
    check("reset ramWData", ramWData, 32'd0);
`ifdef ARB_PERF_COUNTERS_EN
    check("reset ifWaitCycles", ifWaitCycles, 32'd0);
    check("reset memWaitCycles", memWaitCycles, 32'd0);
`endif

    for (int i = 0; i < 6; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
      $display("vec%0d is_if=%0b we=%0b addr=%h exp=%h", i, vecs[i].is_if, vecs[i].we,
               vecs[i].addr, vecs[i].exp_data);
    end

    // Simultaneous fetch and load: data first, fetch issued after it completes.
`ifdef ARB_PERF_COUNTERS_EN
    @(negedge clk);
    if_snap = ifWaitCycles; mem_snap = memWaitCycles;
`endif
    @(posedge clk); #1;
    ifReq = 1'b1; ifAddr = 32'h10; memReq = 1'b1; memWe = 1'b0; memAddr = 32'h40;
    mv = -1; iv = -1; ie = -1; ist = 0;
    for (int k = 0; k < 20 && iv < 0; k++) begin
      @(negedge clk);
      if (ifStall) ist++;
      if (memValid && mv < 0) mv = k;
      if (ramEn && ramAddr == 32'h10 && ie < 0) ie = k;
      if (ifValid) iv = k;
      @(posedge clk); #1;
      if (memValid) memReq = 1'b0;
      if (ifValid) ifReq = 1'b0;
    end
    ifReq = 1'b0; memReq = 1'b0;
    check("simul memValid cycle", mv, 4);
    check("simul fetch ramEn cycle", ie, 6);
    check("simul ifValid cycle", iv, 9);
    check("simul ifStall cycles", ist, 9);
    $display("simul mem=%0d ifEn=%0d if=%0d stall=%0d", mv, ie, iv, ist);
`ifdef ARB_PERF_COUNTERS_EN
    @(negedge clk);
    check("perf memWaitCycles", memWaitCycles - mem_snap, 32'd4);
    check("perf ifWaitCycles", ifWaitCycles - if_snap, 32'd9);
`endif

    // Starvation guard: both requests held continuously.
    exp_order = '{32'h40, 32'h40, 32'h10, 32'h40, 32'h40, 32'h10};
    repeat (3) @(posedge clk);
    #1;
    ifReq = 1'b1; ifAddr = 32'h10; memReq = 1'b1; memWe = 1'b0; memAddr = 32'h40;
    cnt = 0;
    for (int k = 0; k < 60 && cnt < 6; k++) begin
      @(negedge clk);
      if (ramEn) begin
        order[cnt] = ramAddr;
        cnt++;
      end
    end
    @(posedge clk); #1;
    ifReq = 1'b0; memReq = 1'b0;
    check("starve grant count", cnt, 6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("starve grant%0d", i), order[i], exp_order[i]);
      $display("starve grant%0d addr=%h", i, order[i]);
    end
    repeat (8) @(posedge clk);

    // Reset while the load is in WAIT; the access is abandoned.
    @(posedge clk); #1;
    memReq = 1'b1; memWe = 1'b0; memAddr = 32'h40;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; memReq = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst-wait ctrl outputs",
          {26'd0, ramEn, ramWe, ifValid, memValid, ifStall, memStall}, 32'd0);
    check("rst-wait ifData", ifData, 32'd0);
    check("rst-wait memRData", memRData, 32'd0);
    check("rst-wait ramAddr", ramAddr, 32'd0);
    bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (memValid || ifValid || ramEn) bad = 1'b1;
    end
    check("rst-wait no late activity", {31'd0, bad}, 32'd0);
    $display("rst-wait abandoned load checked");
    run_txn(vecs[1], "post-reset load");
    $display("post-reset load addr=%h exp=%h", vecs[1].addr, vecs[1].exp_data);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/unified_memory_arbiter.md
Name: unified_memory_arbiter

Overview:
- Shares one single-ported backing RAM between the instructionFetch port (instruction reads) and the memory-stage port (data loads and stores).
- Sequences each access through a fixed-latency RAM protocol.
- Produces per-port stall signals that freeze the pipeline while a request is pending.
- Data port has priority; a streak limit prevents instruction-fetch starvation.

Parameters:
DATA_WIDTH, 32, width of data and addresses
MEM_LATENCY, 2, cycles from ramEn to valid ramRData (>=1)
DATA_STREAK_MAX, 3, max consecutive data grants while a fetch waits (>=1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
ifReq  in  1  fetch request; held with ifAddr until ifValid
ifAddr  in  DATA_WIDTH  fetch address
ifData  out  DATA_WIDTH  fetched instruction, registered
ifValid  out  1  one-cycle completion pulse, fetch port
ifStall  out  1  ifReq & ~ifValid, combinational
memReq  in  1  data request (memRead | memWrite); held until memValid
memWe  in  1  1 = store, 0 = load
memAddr  in  DATA_WIDTH  data address
memWData  in  DATA_WIDTH  store data
memRData  out  DATA_WIDTH  load data, registered
memValid  out  1  one-cycle completion pulse, data port
memStall  out  1  memReq & ~memValid, combinational
ramEn  out  1  RAM access strobe, one cycle per access, registered
ramWe  out  1  RAM write enable, registered
ramAddr  out  DATA_WIDTH  RAM address, registered
ramWData  out  DATA_WIDTH  RAM write data, registered
ramRData  in  DATA_WIDTH  RAM read data, valid MEM_LATENCY cycles after ramEn

Behaviour:
- Clock and reset: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values:
  - State = IDLE, owner = none, wait counter = 0, streak = 0.
  - ifData, memRData, ramAddr and ramWData = 0.
  - ifValid, memValid, ramEn and ramWe = 0.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE grant rule:
  - memReq && (!ifReq || streak < DATA_STREAK_MAX) -> grant DATA.
  - Else if ifReq -> grant IF.
  - Else stay in IDLE.
- On grant:
  - Latch address, we and wdata of the granted port.
  - Go to ISSUE.
  - Later changes on the inputs are ignored for this transaction.
- Streak counter:
  - On a DATA grant with ifReq high: streak += 1, saturating at DATA_STREAK_MAX.
  - On a DATA grant with ifReq low: streak = 0.
  - On an IF grant: streak = 0.
- ISSUE:
  - ramEn = 1; ramAddr and ramWData driven from the latched values; ramWe = latched we (always 0 for IF).
  - Wait counter loaded with MEM_LATENCY; go to WAIT.
- WAIT:
  - ramEn = 0.
  - Counter decrements each cycle.
  - On the cycle ramRData is valid (counter == 1), capture ramRData into the owner's data register, unless the access is a store.
  - Then go to DONE.
- DONE: assert the owner's valid for exactly one cycle, then return to IDLE.
  - No grant is made in DONE, so a still-high req on a just-completed port is not re-serviced.
- Latency:
  - Request sampled in IDLE at cycle T -> ramEn at T+1 -> valid at T+MEM_LATENCY+2.
  - Back-to-back period: MEM_LATENCY+3 cycles.
- Stores:
  - memValid pulses as the store acknowledge.
  - memRData holds its previous value.
- Stall semantics:
  - Stall stays high through ISSUE and WAIT, even for the port that is not granted.
  - Stall falls in the valid cycle so the pipeline advances.
- Request withdrawn mid-transaction: the transaction completes and valid still pulses.
- Reset mid-transaction:
  - Return to IDLE; all outputs take their reset values.
  - The in-flight access is abandoned; late ramRData is ignored.

Optional Feature:
- Macro: ARB_PERF_COUNTERS_EN.
- When defined, adds outputs ifWaitCycles and memWaitCycles, 32 bits each.
  - Each counts cycles where that port's stall == 1.
  - Both are cleared by reset and wrap modulo 2^32.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- (MEM_LATENCY=2) IF read alone: ifReq=1, ifAddr=0x10 at T; RAM returns 0x8C010004 -> ramEn at T+1 with ramAddr=0x10; ifValid=1 and ifData=0x8C010004 at T+4; ifStall=1 for T..T+3, 0 at T+4.
- Simultaneous: ifReq and memReq (load, memAddr=0x40) at T -> DATA served first (memValid at T+4); ramEn for ifAddr at T+6; ifValid at T+9; ifStall high T..T+8.
- Starvation (DATA_STREAK_MAX=2): memReq and ifReq held high continuously -> grant order DATA, DATA, IF, DATA, DATA, IF; streak returns to 0 after each IF grant.
- Store: memReq=1, memWe=1, memAddr=0x44, memWData=0xDEADBEEF -> ramEn=1, ramWe=1, ramAddr=0x44, ramWData=0xDEADBEEF at T+1; memValid at T+4; memRData unchanged.
- Reset in WAIT: assert reset for 1 cycle at T+2 -> state IDLE, no valid pulse, all outputs 0; a request re-presented after reset completes normally in MEM_LATENCY+2 cycles.
- ARB_PERF_COUNTERS_EN: run the simultaneous scenario -> memWaitCycles=4, ifWaitCycles=9.
